// File: rtl/check_pkg.sv
// Shared definitions for the check block: command codes, CHECK_FIFO field
// layout, FSM states and result-record packing.
package check_pkg;

    // Widths the datapath is built for; the top refuses any other setting.
    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int STF_W  = 24;
    localparam int ORV_W  = 8;
    localparam int CHF_W  = STF_W + ADDR_W + ORV_W;
    localparam int SCC_W  = 5;

    // stim -> check command codes
    localparam logic [SCC_W-1:0] SC_CMD_IDLE    = 5'b00000;
    localparam logic [SCC_W-1:0] SC_CMD_BITMASK = 5'b00001;

    // CHECK_FIFO entry is {expected, vec_addr, orv}
    localparam int CHF_ORV_LSB  = 0;
    localparam int CHF_ADDR_LSB = CHF_ORV_LSB + ORV_W;
    localparam int CHF_EXP_LSB  = CHF_ADDR_LSB + ADDR_W;

    localparam int REC_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_WRITE
    } state_t;

    typedef logic [REC_WORDS-1:0][DATA_W-1:0] record_t;

    // Result record: status/orv word, vector address low half, captured outputs.
    function automatic record_t build_record(
        input logic              fail,
        input logic [ADDR_W-1:0] vec_addr,
        input logic [ORV_W-1:0]  orv,
        input logic [STF_W-1:0]  actual
    );
        record_t rec;
        rec[0] = {fail, 3'b000, vec_addr[19:16], orv};
        rec[1] = vec_addr[15:0];
        rec[2] = {8'h00, actual[23:16]};
        rec[3] = actual[15:0];
        return rec;
    endfunction

endpackage

// File: rtl/check_cmp.sv
// Masked compare of an expected test vector against captured target outputs;
// purely combinational so it can be reused wherever a pass/fail flag is needed.
module check_cmp #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] actual,
    input  logic [WIDTH-1:0] mask,
    output logic             fail
);

    logic [WIDTH-1:0] mismatch;

    // NOTE: continuous assignments only, so no latch can be inferred here.
    assign mismatch = (expected ^ actual) & mask;
    assign fail     = |mismatch;

endmodule

// File: rtl/check.sv
// Consumer of CHECK_FIFO/RESULT_FIFO: compares each test under the current
// output mask and writes a 4-word result record through an Avalon-MM master.
module check
    import check_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 20,
    parameter int                    DATA_WIDTH = 16,
    parameter int                    STF_WIDTH  = 24,
    parameter int                    ORV_WIDTH  = 8,
    parameter int                    CHF_WIDTH  = 52,
    parameter int                    SCC_WIDTH  = 5,
    parameter int                    SCD_WIDTH  = 24,
    parameter int                    CNT_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE   = 20'h80000,
    parameter logic [ADDR_WIDTH-1:0] RES_WORDS  = 20'h40000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CHF_WIDTH-1:0]  cfifo_data,
    output logic                  cfifo_rdreq,
    input  logic                  cfifo_rdempty,
    input  logic [STF_WIDTH-1:0]  rfifo_data,
    output logic                  rfifo_rdreq,
    input  logic                  rfifo_rdempty,
    input  logic [SCC_WIDTH-1:0]  sc_cmd,
    input  logic [SCD_WIDTH-1:0]  sc_data,
    input  logic                  sc_switching,
    output logic                  sc_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [1:0]            mem_byteenable,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic                  mem_waitrequest,
    output logic [CNT_WIDTH-1:0]  checked_count,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic                  res_wrapped
);

    if (ADDR_WIDTH != ADDR_W || DATA_WIDTH != DATA_W || STF_WIDTH != STF_W ||
        ORV_WIDTH != ORV_W || CHF_WIDTH != CHF_W || SCC_WIDTH != SCC_W ||
        SCD_WIDTH != STF_WIDTH || RES_WORDS == '0 || RES_WORDS[1:0] != 2'b00)
    begin : g_param_check
        $error("check: unsupported width or result-region parameters");
    end

    localparam logic [ADDR_WIDTH-1:0] RES_LAST = ADDR_WIDTH'(RES_BASE + RES_WORDS - 1);

    state_t                state;
    logic [STF_WIDTH-1:0]  mask;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [1:0]            idx;

    logic [STF_WIDTH-1:0]  exp_q;
    logic [STF_WIDTH-1:0]  act_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ORV_WIDTH-1:0]  orv_q;
    record_t               rec_q;

    logic                  fail;
    logic                  pop;

    // A mask change is only taken once every queued check has been retired.
    assign sc_ready = (state == ST_IDLE) && cfifo_rdempty;

    // Both FIFOs must have an entry; a lone entry waits for its partner.
    assign pop = (state == ST_IDLE) && !cfifo_rdempty && !rfifo_rdempty && !sc_switching;

    assign mem_byteenable = 2'b11;
    assign mem_address    = wr_ptr;
    assign mem_writedata  = rec_q[idx];

    check_cmp #(
        .WIDTH (STF_WIDTH)
    ) u_cmp (
        .expected (exp_q),
        .actual   (act_q),
        .mask     (mask),
        .fail     (fail)
    );

    // NOTE: datapath holding registers are left out of reset; each is written
    // before the FSM ever reads it, so resetting them only costs logic.
    always_ff @(posedge clock) begin
        if (pop) begin
            exp_q  <= cfifo_data[CHF_EXP_LSB  +: STF_WIDTH];
            addr_q <= cfifo_data[CHF_ADDR_LSB +: ADDR_WIDTH];
            orv_q  <= cfifo_data[CHF_ORV_LSB  +: ORV_WIDTH];
            act_q  <= rfifo_data;
        end
        if (state == ST_COMPARE) begin
            rec_q <= build_record(fail, addr_q, orv_q, act_q);
        end
    end

    // NOTE: non-blocking assignments in clocked blocks so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            mask          <= '1;
            wr_ptr        <= RES_BASE;
            idx           <= '0;
            checked_count <= '0;
            fail_count    <= '0;
            res_wrapped   <= 1'b0;
            cfifo_rdreq   <= 1'b0;
            rfifo_rdreq   <= 1'b0;
            mem_write     <= 1'b0;
        end else begin
            cfifo_rdreq <= 1'b0;
            rfifo_rdreq <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sc_ready && sc_cmd == SC_CMD_BITMASK) begin
                        mask <= sc_data;
                    end else if (pop) begin
                        cfifo_rdreq <= 1'b1;
                        rfifo_rdreq <= 1'b1;
                        state       <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (checked_count != '1) begin
                        checked_count <= checked_count + 1'b1;
                    end
                    if (fail && fail_count != '1) begin
                        fail_count <= fail_count + 1'b1;
                    end
                    idx       <= '0;
                    mem_write <= 1'b1;
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (!mem_waitrequest) begin
                        if (wr_ptr == RES_LAST) begin
                            wr_ptr      <= RES_BASE;
                            res_wrapped <= 1'b1;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                        idx <= idx + 1'b1;
                        if (idx == 2'd3) begin
                            mem_write <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_check.sv
// Directed bench for check: show-ahead FIFO models, an Avalon write slave with
// optional random stalls, and a small record model for expected memory writes.
module tb_check;
    import check_pkg::*;

    localparam logic [19:0] BASE  = 20'h80000;
    localparam logic [19:0] WORDS = 20'h00008;
    localparam logic [19:0] LAST  = 20'h80007;

    logic        clock;
    logic        reset;
    logic [51:0] cfifo_data;
    logic        cfifo_rdreq;
    logic        cfifo_rdempty;
    logic [23:0] rfifo_data;
    logic        rfifo_rdreq;
    logic        rfifo_rdempty;
    logic [4:0]  sc_cmd;
    logic [23:0] sc_data;
    logic        sc_switching;
    logic        sc_ready;
    logic [19:0] mem_address;
    logic [1:0]  mem_byteenable;
    logic        mem_write;
    logic [15:0] mem_writedata;
    logic        mem_waitrequest;
    logic [15:0] checked_count;
    logic [15:0] fail_count;
    logic        res_wrapped;

    check #(
        .RES_BASE  (BASE),
        .RES_WORDS (WORDS)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .cfifo_data      (cfifo_data),
        .cfifo_rdreq     (cfifo_rdreq),
        .cfifo_rdempty   (cfifo_rdempty),
        .rfifo_data      (rfifo_data),
        .rfifo_rdreq     (rfifo_rdreq),
        .rfifo_rdempty   (rfifo_rdempty),
        .sc_cmd          (sc_cmd),
        .sc_data         (sc_data),
        .sc_switching    (sc_switching),
        .sc_ready        (sc_ready),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_waitrequest (mem_waitrequest),
        .checked_count   (checked_count),
        .fail_count      (fail_count),
        .res_wrapped     (res_wrapped)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // FIFO contents: main process fills tables and write indices, FIFO process pops.
    logic [51:0] c_tab [0:63];
    logic [23:0] r_tab [0:63];
    int c_wr = 0, r_wr = 0, r_pend = 0;
    int c_rd = 0, r_rd = 0, cyc = 0, n_pops = 0, split_pops = 0;
    int pop_cyc [0:63];

    initial begin
        cfifo_rdempty = 1'b1;
        rfifo_rdempty = 1'b1;
        cfifo_data    = '0;
        rfifo_data    = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (cfifo_rdreq != rfifo_rdreq) split_pops++;
            if (cfifo_rdreq) begin
                pop_cyc[n_pops % 64] = cyc;
                n_pops++;
                c_rd++;
            end
            if (rfifo_rdreq) r_rd++;
            cfifo_rdempty = (c_rd >= c_wr);
            rfifo_rdempty = (r_rd >= r_wr);
            cfifo_data    = c_tab[c_rd % 64];
            rfifo_data    = r_tab[r_rd % 64];
        end
    end

    // Avalon write slave: logs accepted words, optionally stalls 0-5 cycles per word.
    logic [19:0] log_a [0:127];
    logic [15:0] log_d [0:127];
    int   n_wr = 0, unstable = 0, stall_left = 0;
    bit   rand_wait = 1'b0;
    bit   was_stalled = 1'b0;
    logic [19:0] hold_a;
    logic [15:0] hold_d;

    initial begin
        mem_waitrequest = 1'b0;
        forever begin
            @(negedge clock);
            if (was_stalled && (mem_write !== 1'b1 || mem_address !== hold_a || mem_writedata !== hold_d))
                unstable++;
            if (mem_write === 1'b1) begin
                if (!was_stalled) stall_left = rand_wait ? int'($urandom_range(5, 0)) : 0;
                if (stall_left > 0) begin
                    mem_waitrequest = 1'b1;
                    stall_left--;
                    was_stalled = 1'b1;
                    hold_a = mem_address;
                    hold_d = mem_writedata;
                end else begin
                    mem_waitrequest = 1'b0;
                    was_stalled = 1'b0;
                    log_a[n_wr % 128] = mem_address;
                    log_d[n_wr % 128] = mem_writedata;
                    n_wr++;
                end
            end else begin
                mem_waitrequest = 1'b0;
                was_stalled = 1'b0;
            end
        end
    end

    // Expected-record model
    logic [19:0] exp_a [0:127];
    logic [15:0] exp_d [0:127];
    int          n_exp = 0, n_chk = 0, m_checked = 0, m_fail = 0;
    logic [19:0] m_ptr  = BASE;
    logic        m_wrap = 1'b0;
    logic [23:0] m_mask = 24'hFFFFFF;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    task automatic queue_vec(input logic [23:0] e, input logic [23:0] a,
                             input logic [19:0] addr, input logic [7:0] orv, input bit with_r);
        logic        f;
        logic [15:0] w [4];
        c_tab[c_wr % 64]   = {e, addr, orv};
        r_tab[r_pend % 64] = a;
        r_pend++;
        c_wr++;
        if (with_r) r_wr = r_pend;
        f    = |((e ^ a) & m_mask);
        w[0] = {f, 3'b000, addr[19:16], orv};
        w[1] = addr[15:0];
        w[2] = {8'h00, a[23:16]};
        w[3] = a[15:0];
        for (int k = 0; k < 4; k++) begin
            exp_a[n_exp % 128] = m_ptr;
            exp_d[n_exp % 128] = w[k];
            n_exp++;
            if (m_ptr == LAST) begin
                m_ptr  = BASE;
                m_wrap = 1'b1;
            end else begin
                m_ptr = m_ptr + 20'd1;
            end
        end
        m_checked++;
        if (f) m_fail++;
    endtask

    task automatic wait_records();
        int budget = 400;
        while (n_wr < n_exp && budget > 0) begin
            step(1);
            budget--;
        end
        step(1);
        check("words_written", n_wr, n_exp);
        for (int i = n_chk; i < n_exp; i++) begin
            check("rec_addr", log_a[i % 128], exp_a[i % 128]);
            check("rec_data", log_d[i % 128], exp_d[i % 128]);
        end
        n_chk = n_exp;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_checked"}, checked_count, m_checked);
        check({tag, "_failed"}, fail_count, m_fail);
        check({tag, "_wrapped"}, res_wrapped, m_wrap);
    endtask

    task automatic model_reset();
        m_ptr     = BASE;
        m_wrap    = 1'b0;
        m_mask    = 24'hFFFFFF;
        m_checked = 0;
        m_fail    = 0;
        n_exp     = n_wr;
        n_chk     = n_wr;
    endtask

    initial begin
        int rec0;
        int pops0;
        int budget;
        reset        = 1'b1;
        sc_cmd       = SC_CMD_IDLE;
        sc_data      = '0;
        sc_switching = 1'b0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_rdreq", {cfifo_rdreq, rfifo_rdreq}, 2'b00);
        check("rst_sc_ready", sc_ready, 1'b1);
        check("rst_byteenable", mem_byteenable, 2'b11);
        check_counts("rst");

        // 1: matching vector under the all-ones mask
        rec0 = n_exp;
        queue_vec(24'h123456, 24'h123456, 20'h00010, 8'hA5, 1'b1);
        wait_records();
        check("t1_a0", log_a[rec0 % 128], 20'h80000);
        check("t1_a3", log_a[(rec0 + 3) % 128], 20'h80003);
        check("t1_w0", log_d[rec0 % 128], 16'h00A5);
        check("t1_w1", log_d[(rec0 + 1) % 128], 16'h0010);
        check("t1_w2", log_d[(rec0 + 2) % 128], 16'h0012);
        check("t1_w3", log_d[(rec0 + 3) % 128], 16'h3456);
        check_counts("t1");

        // 2: one-bit mismatch flags fail
        rec0 = n_exp;
        queue_vec(24'h123456, 24'h123457, 20'h00010, 8'hA5, 1'b1);
        wait_records();
        check("t2_w0", log_d[rec0 % 128], 16'h80A5);
        check_counts("t2");

        // 3: mask accepted while CHECK_FIFO is empty, bit 0 then ignored
        check("t3_sc_ready", sc_ready, 1'b1);
        sc_cmd  = SC_CMD_BITMASK;
        sc_data = 24'hFFFFFE;
        step(1);
        sc_cmd = SC_CMD_IDLE;
        m_mask = 24'hFFFFFE;
        rec0 = n_exp;
        queue_vec(24'h123456, 24'h123457, 20'h00010, 8'hA5, 1'b1);
        wait_records();
        check("t3_w0_pass", log_d[rec0 % 128][15], 1'b0);
        check_counts("t3");

        // 4: mask request held off while a check is queued; queued check uses old mask
        rec0 = n_exp;
        queue_vec(24'h123456, 24'h123457, 20'h00020, 8'h3C, 1'b0);
        pops0 = n_pops;
        step(3);
        sc_cmd  = SC_CMD_BITMASK;
        sc_data = 24'hFFFFFF;
        step(3);
        check("t4_lone_no_pop", n_pops, pops0);
        check("t4_not_ready", sc_ready, 1'b0);
        r_wr = r_pend;
        budget = 200;
        while (!sc_ready && budget > 0) begin
            step(1);
            budget--;
        end
        check("t4_ready_after_record", n_wr, n_exp);
        step(1);
        sc_cmd = SC_CMD_IDLE;
        m_mask = 24'hFFFFFF;
        wait_records();
        check("t4_old_mask_w0", log_d[rec0 % 128], 16'h003C);
        rec0 = n_exp;
        queue_vec(24'h123456, 24'h123457, 20'h00030, 8'hC3, 1'b1);
        wait_records();
        check("t4_new_mask_w0", log_d[rec0 % 128], 16'h80C3);
        check_counts("t4");

        // sc_switching blocks new pops but not a record already in flight
        sc_switching = 1'b1;
        pops0 = n_pops;
        queue_vec(24'h00FF00, 24'h00FF00, 20'h3ABCD, 8'h11, 1'b1);
        step(6);
        check("sw_blocks_pop", n_pops, pops0);
        sc_switching = 1'b0;
        budget = 50;
        while (mem_write !== 1'b1 && budget > 0) begin
            step(1);
            budget--;
        end
        sc_switching = 1'b1;
        wait_records();
        sc_switching = 1'b0;

        // Back-to-back throughput: 6 cycles pop to pop
        queue_vec(24'hA5A5A5, 24'h5A5A5A, 20'h00100, 8'h01, 1'b1);
        queue_vec(24'hFFFFFF, 24'hFFFFFF, 20'h00104, 8'h02, 1'b1);
        wait_records();
        check("throughput_gap", pop_cyc[(n_pops - 1) % 64] - pop_cyc[(n_pops - 2) % 64], 6);

        // 5: random wait states
        rand_wait = 1'b1;
        queue_vec(24'h0ABCDE, 24'h0ABCDE, 20'hF1234, 8'h5A, 1'b1);
        queue_vec(24'h000000, 24'hFFFFFF, 20'h00002, 8'h77, 1'b1);
        queue_vec(24'h800000, 24'h000000, 20'h7FFFF, 8'h80, 1'b1);
        wait_records();
        rand_wait = 1'b0;
        check("t5_stable", unstable, 0);
        check_counts("t5");

        // 6: reset, then wrap on the third record
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        model_reset();
        step(1);
        check_counts("t6_rst");
        queue_vec(24'h111111, 24'h111111, 20'h00001, 8'h01, 1'b1);
        wait_records();
        check("t6_no_wrap_yet", res_wrapped, 1'b0);
        queue_vec(24'h222222, 24'h222222, 20'h00002, 8'h02, 1'b1);
        rec0 = n_exp;
        queue_vec(24'h333333, 24'h333334, 20'h00003, 8'h03, 1'b1);
        wait_records();
        check("t6_third_at_base", log_a[rec0 % 128], 20'h80000);
        check("t6_wrapped", res_wrapped, 1'b1);
        check_counts("t6");

        // Reset in the middle of a record abandons it
        rec0 = n_wr;
        queue_vec(24'h444444, 24'h444444, 20'h00004, 8'h04, 1'b1);
        budget = 50;
        while (n_wr <= rec0 && budget > 0) begin
            step(1);
            budget--;
        end
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(10);
        check("abort_words", n_wr, rec0 + 1);
        check("abort_first_addr", log_a[rec0 % 128], 20'h80004);
        check("abort_mem_write", mem_write, 1'b0);
        model_reset();
        rec0 = n_exp;
        queue_vec(24'h555555, 24'h555555, 20'h00005, 8'h05, 1'b1);
        wait_records();
        check("post_abort_base", log_a[rec0 % 128], 20'h80000);
        check_counts("post_abort");

        check("paired_pops", split_pops, 0);
        check("pop_total", n_pops, c_wr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
